// File: rtl/test_end_monitor.sv
// End-of-test controller: turns done/error/watchdog events into one
// sticky verdict (finished/passed/exit_code/timed_out) plus a finish pulse.
//
// Ports:
//   clock, reset        clock; synchronous active-low reset
//   done_valid/ready    done handshake, done_code (0 = pass)
//   error_valid         fatal error (pulse or level), error_code
//   finished            sticky, verdict valid
//   finish_pulse        one cycle high on entry to DONE
//   passed, exit_code   sticky verdict
//   timed_out           sticky, watchdog fired
//   cycle_count         saturating count of RUN/DRAIN cycles
module test_end_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int          CODE_W         = 8,
  parameter int          CNT_W          = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              done_valid,
  output logic              done_ready,
  input  logic [CODE_W-1:0] done_code,
  input  logic              error_valid,
  input  logic [CODE_W-1:0] error_code,
  output logic              finished,
  output logic              finish_pulse,
  output logic              passed,
  output logic [CODE_W-1:0] exit_code,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DW =
    (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  localparam bit HAS_DRAIN = (DRAIN_CYCLES != 0);
  localparam bit HAS_TO    = (TIMEOUT_CYCLES != 0);

  localparam logic [DW-1:0] DRAIN_LOAD =
    HAS_DRAIN ? DW'(DRAIN_CYCLES - 1) : '0;

  // Watchdog fires on the edge that sees the last allowed count.
  localparam logic [CNT_W-1:0] TO_LAST =
    HAS_TO ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_ALL1 = '1;
  localparam logic [CNT_W-1:0]  CNT_ALL1  = '1;

  logic [1:0]        r_state;
  logic [DW-1:0]     r_drain;
  logic [CNT_W-1:0]  r_count;
  logic              r_finished;
  logic              r_pulse;
  logic              r_passed;
  logic [CODE_W-1:0] r_exit;
  logic              r_timed_out;

  logic              w_in_run;
  logic              w_accept;
  logic              w_run_err;
  logic              w_run_to;
  logic              w_cnt_max;
  logic              w_cnt_en;
  logic              w_drain_zero;
  logic [CODE_W-1:0] w_err_code;

  logic [1:0]        w_state_nx;
  logic [DW-1:0]     w_drain_nx;
  logic [CODE_W-1:0] w_exit_nx;
  logic              w_passed_nx;
  logic              w_to_nx;
  logic              w_enter_done;

  assign w_in_run   = (r_state == S_RUN);
  assign done_ready = w_in_run && !error_valid;

  // done_ready already excludes error, so accept and error never
  // overlap; the watchdog loses to both.
  assign w_accept  = done_valid && done_ready;
  assign w_run_err = w_in_run && error_valid;
  assign w_run_to  = HAS_TO && w_in_run
                  && (r_count == TO_LAST)
                  && !error_valid && !w_accept;

  // An error code of zero would look like a pass, so it becomes 1.
  assign w_err_code =
    (error_code == '0) ? CODE_ONE : error_code;

  assign w_cnt_max    = (r_count == CNT_ALL1);
  assign w_cnt_en     = (r_state != S_DONE) && !w_cnt_max;
  assign w_drain_zero = (r_drain == '0);

  always_comb begin
    w_state_nx   = r_state;
    w_drain_nx   = r_drain;
    w_exit_nx    = r_exit;
    w_passed_nx  = r_passed;
    w_to_nx      = r_timed_out;
    w_enter_done = 1'b0;
    unique case (r_state)
      S_RUN: begin
        unique case (1'b1)
          w_run_err: begin
            w_state_nx   = S_DONE;
            w_exit_nx    = w_err_code;
            w_passed_nx  = 1'b0;
            w_enter_done = 1'b1;
          end
          (w_accept && HAS_DRAIN): begin
            w_state_nx = S_DRAIN;
            w_exit_nx  = done_code;
            w_drain_nx = DRAIN_LOAD;
          end
          (w_accept && !HAS_DRAIN): begin
            w_state_nx   = S_DONE;
            w_exit_nx    = done_code;
            w_passed_nx  = (done_code == '0);
            w_enter_done = 1'b1;
          end
          w_run_to: begin
            w_state_nx   = S_DONE;
            w_exit_nx    = CODE_ALL1;
            w_passed_nx  = 1'b0;
            w_to_nx      = 1'b1;
            w_enter_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_DRAIN: begin
        if (error_valid) begin
          w_state_nx   = S_DONE;
          w_exit_nx    = w_err_code;
          w_passed_nx  = 1'b0;
          w_enter_done = 1'b1;
        end else if (w_drain_zero) begin
          w_state_nx   = S_DONE;
          w_passed_nx  = (r_exit == '0);
          w_enter_done = 1'b1;
        end else begin
          w_drain_nx = r_drain - DW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_drain     <= '0;
      r_count     <= '0;
      r_finished  <= 1'b0;
      r_pulse     <= 1'b0;
      r_passed    <= 1'b0;
      r_exit      <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_drain     <= w_drain_nx;
      r_exit      <= w_exit_nx;
      r_passed    <= w_passed_nx;
      r_timed_out <= w_to_nx;
      r_finished  <= r_finished | w_enter_done;
      r_pulse     <= w_enter_done;
      if (w_cnt_en) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign finished     = r_finished;
  assign finish_pulse = r_pulse;
  assign passed       = r_passed;
  assign exit_code    = r_exit;
  assign timed_out    = r_timed_out;
  assign cycle_count  = r_count;

endmodule

// File: tb/tb_test_end_monitor.sv
// Bench for test_end_monitor: directed and random runs checked
// against an event-ordering model of the verdict.
module tb_test_end_monitor;

  localparam int TO  = 100;
  localparam int DR  = 4;
  localparam int INF = 100000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        done_valid = 1'b0;
  logic        done_ready;
  logic [7:0]  done_code = '0;
  logic        error_valid = 1'b0;
  logic [7:0]  error_code = '0;
  logic        finished;
  logic        finish_pulse;
  logic        passed;
  logic [7:0]  exit_code;
  logic        timed_out;
  logic [63:0] cycle_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  test_end_monitor #(
    .TIMEOUT_CYCLES(TO),
    .DRAIN_CYCLES(DR),
    .CODE_W(8),
    .CNT_W(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_code(done_code),
    .error_valid(error_valid),
    .error_code(error_code),
    .finished(finished),
    .finish_pulse(finish_pulse),
    .passed(passed),
    .exit_code(exit_code),
    .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".finished"}, finished, 0);
    chk({tag, ".pulse"}, finish_pulse, 0);
    chk({tag, ".passed"}, passed, 0);
    chk({tag, ".timed_out"}, timed_out, 0);
    chk({tag, ".exit"}, exit_code, 0);
    chk({tag, ".count"}, cycle_count, 0);
  endtask

  // Called at a negedge; returns just after the next negedge with
  // reset released and the DUT one cycle short of its first edge.
  task automatic do_reset(input int n);
    reset       = 1'b0;
    done_valid  = 1'b0;
    error_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      chk_zero("in_reset");
      chk("in_reset.ready", done_ready, 1);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_zero("released");
  endtask

  // da/ea: cycle_count value at which done / error is pulsed
  // (-1 = never). Post-verdict cycles get random input noise.
  task automatic run(input string nm,
                     input int da, input logic [7:0] dc,
                     input int ea, input logic [7:0] ec,
                     input int extra, input int stop_at);
    int ra;
    int ie;
    int run_end;
    int fin;
    int n;
    logic [7:0] code;
    logic pas;
    logic tout;
    bit drain_path;
    logic [63:0] e_exit;

    // Verdict from event order: first of error / accept / watchdog
    // ends RUN; an error inside the drain window overrides a done.
    ra = (da >= 0 && da <= TO - 1) ? da : INF;
    ie = (ea >= 0) ? ea : INF;
    drain_path = 0;
    tout = 0;
    if (ie <= ra && ie <= TO - 1) begin
      run_end = ie;
      fin = ie + 1;
      code = (ec == 0) ? 8'h01 : ec;
      pas = 0;
    end else if (ra != INF) begin
      drain_path = 1;
      run_end = ra;
      if (ie > ra && ie <= ra + DR) begin
        fin = ie + 1;
        code = (ec == 0) ? 8'h01 : ec;
        pas = 0;
      end else begin
        fin = ra + DR + 1;
        code = dc;
        pas = (dc == 0);
      end
    end else begin
      run_end = TO - 1;
      fin = TO;
      code = 8'hFF;
      pas = 0;
      tout = 1;
    end

    for (int k = 0; k < fin + extra; k++) begin
      if (stop_at >= 0 && k == stop_at) break;
      if (k < fin) begin
        done_valid  = (k == da);
        error_valid = (k == ea);
      end else begin
        done_valid  = 1'($urandom_range(0, 1));
        error_valid = 1'($urandom_range(0, 1));
      end
      done_code  = (k == da) ? dc : 8'($urandom);
      error_code = (k == ea) ? ec : 8'($urandom);
      #1;
      chk({nm, ".ready"}, done_ready,
          (k < fin && k <= run_end && k != ea) ? 1 : 0);
      @(posedge clock);
      #1;
      n = k + 1;
      if (n >= fin) e_exit = code;
      else if (drain_path && n > run_end) e_exit = dc;
      else e_exit = 0;
      chk({nm, ".count"}, cycle_count, (n < fin) ? n : fin);
      chk({nm, ".finished"}, finished, (n >= fin) ? 1 : 0);
      chk({nm, ".pulse"}, finish_pulse, (n == fin) ? 1 : 0);
      chk({nm, ".passed"}, passed, (n >= fin) ? pas : 0);
      chk({nm, ".timed_out"}, timed_out, (n >= fin) ? tout : 0);
      chk({nm, ".exit"}, exit_code, e_exit);
      @(negedge clock);
    end
    done_valid  = 1'b0;
    error_valid = 1'b0;
  endtask

  initial begin
    int da;
    int ea;
    logic [7:0] dc;
    logic [7:0] ec;

    do_reset(3);
    run("pass", 10, 8'h00, -1, 8'h00, 6, -1);
    do_reset(3);
    run("fail_done", 5, 8'h2A, -1, 8'h00, 6, -1);
    do_reset(3);
    run("wdog", -1, 8'h00, -1, 8'h00, 50, -1);
    do_reset(3);
    run("err_drain", 20, 8'h00, 22, 8'h05, 6, -1);
    do_reset(3);
    run("err_zero", -1, 8'h00, 3, 8'h00, 6, -1);
    do_reset(3);
    run("simul", 8, 8'h00, 8, 8'h07, 6, -1);
    do_reset(3);
    run("err99", -1, 8'h00, 99, 8'h09, 6, -1);
    do_reset(3);
    run("done99", 99, 8'h00, -1, 8'h00, 6, -1);
    do_reset(3);
    run("abort", 10, 8'h00, -1, 8'h00, 0, 12);
    do_reset(1);
    run("pass2", 10, 8'h00, -1, 8'h00, 8, -1);

    for (int r = 0; r < 12; r++) begin
      do_reset($urandom_range(1, 3));
      da = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 110);
      ea = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 115);
      dc = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      ec = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      run("rand", da, dc, ea, ec, 4, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/test_end_monitor.md
Name: test_end_monitor

Overview:
- Tester-side end-of-test controller. Consumes the clock and reset the harness supplies, and returns a single, unambiguous test verdict for the harness to act on.
- Accepts a done handshake or an error indication from the test logic, and applies a drain period after a done.
- Enforces a watchdog timeout.
- Presents sticky finished/passed/exit_code outputs plus a one-cycle finish pulse and a run-cycle count.

Parameters:
- TIMEOUT_CYCLES, 1000000: watchdog limit in run cycles; 0 disables the watchdog.
- DRAIN_CYCLES, 16: cycles spent in DRAIN after a done is accepted; 0 means go directly to DONE.
- CODE_W, 8: width of done_code, error_code and exit_code.
- CNT_W, 64: width of cycle_count.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- done_valid  in  1  test logic requests end of test.
- done_ready  out  1  done handshake accept.
- done_code  in  CODE_W  0 = pass, nonzero = fail code.
- error_valid  in  1  fatal error; single-cycle or level.
- error_code  in  CODE_W  error code.
- finished  out  1  sticky; verdict is valid.
- finish_pulse  out  1  one cycle high on entry to DONE.
- passed  out  1  sticky verdict.
- exit_code  out  CODE_W  final code.
- timed_out  out  1  sticky; watchdog fired.
- cycle_count  out  CNT_W  run cycles elapsed.

Behaviour:
- Reset is sampled on the rising edge of clock. Reset is active-low: reset=0 resets.
- Values while reset=0 and on the first cycle after release:
  - state=RUN.
  - cycle_count=0.
  - finished, finish_pulse, passed, timed_out = 0.
  - exit_code = 0.
  - drain counter = 0.
- States:
  - RUN: waiting for a done, an error, or the timeout.
  - DRAIN: done accepted; allowing in-flight activity to settle.
  - DONE: terminal. Sticky until reset is asserted.
- done_ready is combinational: done_ready = (state==RUN) && !error_valid. It is 0 in DRAIN and DONE.
  - Accept occurs on a rising edge with done_valid && done_ready.
  - done_valid outside RUN is ignored and has no effect.
- cycle_count:
  - Increments on every edge where state is RUN or DRAIN, including the edge that leaves to DONE.
  - Frozen in DONE.
  - Saturates at all-ones and does not wrap.
- RUN transitions, priority error > done accept > timeout:
  - error_valid: go to DONE.
    - exit_code = error_code, or 1 if error_code==0.
    - passed = 0.
  - Done accept, DRAIN_CYCLES>0: go to DRAIN.
    - Latch exit_code = done_code.
    - Load drain counter = DRAIN_CYCLES-1.
  - Done accept, DRAIN_CYCLES==0: go to DONE.
    - exit_code = done_code.
    - passed = (done_code==0).
  - Timeout: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 on this edge with no error and no accept. Go to DONE with:
    - timed_out = 1.
    - passed = 0.
    - exit_code = all-ones.
- DRAIN transitions:
  - error_valid: go to DONE.
    - exit_code = error_code (0 maps to 1).
    - passed = 0.
    - The latched done code is discarded.
  - Otherwise, when drain counter==0: go to DONE with passed = (exit_code==0).
  - Otherwise: decrement the drain counter.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
  - The watchdog is not evaluated in DRAIN.
- Every transition into DONE sets finished=1 and finish_pulse=1 on that edge. finish_pulse clears on the next edge.
- DONE:
  - All inputs are ignored.
  - Outputs are held until reset is asserted.
- Reset asserted mid-RUN, mid-DRAIN or in DONE: all state and outputs return to their reset values on that edge. The next run starts fresh.
- All outputs are registered except done_ready.

Test Plan (TIMEOUT_CYCLES=100, DRAIN_CYCLES=4, CODE_W=8):
1. Pass with drain.
   - Stimulus: hold reset=0 for 3 cycles, release; assert done_valid with done_code=0x00 at cycle_count=10.
   - Response:
     - done_ready=1 and the handshake is accepted.
     - DRAIN covers counts 11..14.
     - DONE is entered with cycle_count=15, finished=1, passed=1, exit_code=0x00, timed_out=0.
     - finish_pulse is high for exactly 1 cycle.
2. Fail via done.
   - Stimulus: done_code=0x2A accepted at count 5.
   - Response: finished at count 10, passed=0, exit_code=0x2A.
3. Watchdog.
   - Stimulus: no inputs after reset release.
   - Response:
     - finished=1 with cycle_count=100, timed_out=1, passed=0, exit_code=0xFF.
     - cycle_count stays 100 for a further 50 cycles.
4. Error during drain, and zero error code.
   - Stimulus, first run: done 0x00 accepted at count 20; error_valid with error_code=0x05 at count 22.
   - Response, first run: DONE with cycle_count=23, exit_code=0x05, passed=0.
   - Stimulus, second run (after reset): error_code=0x00 at count 3.
   - Response, second run: exit_code=0x01.
5. Simultaneous events.
   - Stimulus: done_valid and error_valid (0x07) together at count 8.
   - Response: done_ready=0 that cycle; exit_code=0x07, passed=0.
   - Stimulus: error_valid (0x09) at count 99.
   - Response: exit_code=0x09, timed_out=0.
6. Reset mid-operation and post-DONE inputs.
   - Stimulus: assert reset=0 during DRAIN.
   - Response: all outputs 0 on the next edge; a subsequent pass run behaves as scenario 1.
   - Stimulus: done_valid pulses after DONE.
   - Response: done_ready=0 and the verdict is unchanged.
